i2c_txn_scheduler: RTL and testbench
====================================

# i2c_txn_scheduler

Arbitrating transaction sequencer in front of the byte-level I2C master core. It accepts whole I2C transactions (address, direction, byte count) from up to NUM_REQ requesters and grants them round-robin. It breaks each granted transaction into byte-level commands (START, WRITE, READ_ACK, READ_NAK, STOP) and handles the write-data and read-data byte streams. It reports a per-transaction completion status back to the owning requester.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- I2C_ADDR_WIDTH, 7: slave address width
- I2C_DATA_WIDTH, 8: data byte width
- LEN_WIDTH, 4: byte-count width (0..15 bytes per transaction)
- clk_i  in  1  system clock
- rst_n_i  in  1  reset; one clock; reset is asynchronous and active-low
- req_valid_i  in  NUM_REQ  per-requester transaction request
- req_ready_o  out  NUM_REQ  one-cycle accept pulse to the granted requester
- req_addr_i  in  NUM_REQ*I2C_ADDR_WIDTH  slave address, flattened, requester 0 in LSBs
- req_op_i  in  NUM_REQ  0=write, 1=read
- req_len_i  in  NUM_REQ*LEN_WIDTH  byte count; 0 = address-only probe
- wr_valid_i  in  NUM_REQ  write-byte valid
- wr_data_i  in  NUM_REQ*I2C_DATA_WIDTH  write bytes, flattened
- wr_ready_o  out  NUM_REQ  write-byte accept; asserted only for the granted requester
- rd_valid_o  out  1  read byte valid (single-cycle pulse)
- rd_data_o  out  I2C_DATA_WIDTH  read byte
- rd_last_o  out  1  final byte of the transaction
- gnt_id_o  out  $clog2(NUM_REQ)  current owner; qualifies rd_* and done_*
- busy_o  out  1  transaction in progress
- cmd_valid_o  out  1  byte-level command valid
- cmd_ready_i  in  1  core accepts command
- cmd_code_o  out  3  001 WRITE, 010 READ_ACK, 011 READ_NAK, 100 START, 101 STOP
- cmd_wdata_o  out  I2C_DATA_WIDTH  byte for WRITE
- rsp_valid_i  in  1  core response pulse
- rsp_status_i  in  2  00 DONE, 01 NAK, 10 ARB_LOST, 11 ERROR
- rsp_rdata_i  in  I2C_DATA_WIDTH  read byte, valid with rsp_valid_i on READ_*
- done_valid_o  out  1  completion pulse
- done_status_o  out  2  same encoding as rsp_status_i

## Operation
- States:
  - IDLE: selects a requester when any req_valid_i is high.
  - GRANT: pulses req_ready_o and latches addr/op/len into internal registers.
  - START: issues the START command.
  - ADDR: issues WRITE {addr, op}.
  - WFETCH: raises wr_ready_o until the byte handshake completes, then issues WRITE.
  - RDATA: issues READ_ACK or READ_NAK.
  - STOP: issues the STOP command.
  - REPORT: pulses done_valid_o, then returns to IDLE.
- Round-robin: the search starts at pointer rr. After REPORT, rr = granted id + 1, modulo NUM_REQ.
- One command outstanding at a time. Each command state has two phases:
  - CMD: holds cmd_valid_o and its data until cmd_ready_i.
  - WAIT: waits for rsp_valid_i.
- Byte counter: loaded with len and decremented per data byte. The last read byte uses READ_NAK; all other read bytes use READ_ACK.
- Transitions after ADDR:
  - len=0 → STOP.
  - op=0 → WFETCH.
  - op=1 → RDATA.
- Transition after the last data byte: → STOP.
- Error handling:
  - NAK on address or on a write byte → STOP, then report NAK.
  - ARB_LOST on any command → skip STOP, report ARB_LOST.
  - ERROR on any command → STOP, report ERROR.
  - A NAK or ERROR response to STOP itself is reported as ERROR.
- rd_valid_o pulses in the cycle after each READ_* DONE response. rd_last_o is high on the final byte.
- gnt_id_o and busy_o are stable from GRANT through REPORT inclusive.

## Timing
- Reset values:
  - All outputs 0; rr = 0; state IDLE.
  - Internal counters and latched request fields are cleared.
- Grant latency: req_valid_i seen in IDLE → req_ready_o in the next cycle (GRANT). START cmd_valid_o follows in the cycle after that.
- Requester handshakes:
  - req_valid_i may drop after req_ready_o; fields are sampled only at GRANT.
  - Write data: the byte transfers on a cycle where wr_valid_i & wr_ready_o are both high. WRITE is issued in the following cycle.
  - A requester that withholds wr_valid_i stalls the bus indefinitely; no timeout.
- Command handshake: cmd_valid_o stays asserted with stable code and data until cmd_ready_i; it deasserts in the cycle after acceptance.
- Response handling: rsp_valid_i is ignored outside WAIT.
- Done reporting: done_valid_o is exactly 1 cycle. A new grant is possible in the cycle after REPORT.
- Simultaneous requests: the lowest index at or above rr wins, with wrap-around.
- Asynchronous reset mid-transaction: the FSM returns to IDLE immediately and all outputs go to 0. No STOP is issued; the core shares rst_n_i and recovers the bus itself.

## Test plan
- Write, 2 bytes: req0 write, addr 0x22, len 2, data 0xA5, 0x5A, all responses DONE → commands START, WRITE 0x44, WRITE 0xA5, WRITE 0x5A, STOP; done_status 00, gnt_id 0.
- Read, 3 bytes: req1 read, addr 0x22, len 3, rdata 0x11/0x22/0x33 → commands START, WRITE 0x45, READ_ACK, READ_ACK, READ_NAK, STOP; three rd_valid pulses, rd_last on 0x33; done 00.
- Address NAK: req2 write, addr 0x10, len 4; NAK on the address byte → START, WRITE 0x20, STOP; no wr_ready pulses; done_status 01.
- Arbitration lost: ARB_LOST returned on the second data WRITE → no STOP issued; done_status 10; next grant proceeds normally.
- Contention: all four req_valid high continuously with rr=0, len=0 probes → grant order 0,1,2,3,0; each probe issues START, WRITE {addr,op}, STOP.
- Reset mid-op: assert rst_n_i low during a read's second READ_ACK WAIT → same cycle cmd_valid_o=0, busy_o=0, state IDLE, rr=0; after release, req3 is granted first when it is the only requester.

Source files
------------

// File: rtl/i2c_txn_scheduler.sv
// Round-robin transaction sequencer in front of a byte-level I2C master core.
// Splits each granted transaction into START / address / data / STOP commands.
module i2c_txn_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8,
  parameter int LEN_WIDTH      = 4,
  localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ*I2C_ADDR_WIDTH-1:0]  req_addr_i,
  input  logic [NUM_REQ-1:0]                 req_op_i,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]       req_len_i,
  input  logic [NUM_REQ-1:0]                 wr_valid_i,
  input  logic [NUM_REQ*I2C_DATA_WIDTH-1:0]  wr_data_i,
  output logic [NUM_REQ-1:0]                 wr_ready_o,
  output logic                               rd_valid_o,
  output logic [I2C_DATA_WIDTH-1:0]          rd_data_o,
  output logic                               rd_last_o,
  output logic [ID_W-1:0]                    gnt_id_o,
  output logic                               busy_o,
  output logic                               cmd_valid_o,
  input  logic                               cmd_ready_i,
  output logic [2:0]                         cmd_code_o,
  output logic [I2C_DATA_WIDTH-1:0]          cmd_wdata_o,
  input  logic                               rsp_valid_i,
  input  logic [1:0]                         rsp_status_i,
  input  logic [I2C_DATA_WIDTH-1:0]          rsp_rdata_i,
  output logic                               done_valid_o,
  output logic [1:0]                         done_status_o
);

  typedef enum logic [3:0] {
    IDLE, GRANT, START_CMD, START_WAIT, ADDR_CMD, ADDR_WAIT, WFETCH, WR_CMD,
    WR_WAIT, RD_CMD, RD_WAIT, STOP_CMD, STOP_WAIT, REPORT
  } state_t;

  localparam logic [2:0] C_WRITE = 3'b001, C_RACK = 3'b010, C_RNAK = 3'b011;
  localparam logic [2:0] C_START = 3'b100, C_STOP = 3'b101;
  localparam logic [1:0] ST_DONE = 2'b00, ST_NAK = 2'b01, ST_ARB = 2'b10, ST_ERR = 2'b11;
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   NREQ_W  = (ID_W+1)'(NUM_REQ);

  state_t                    state;
  logic [ID_W-1:0]           rr, gnt;
  logic [I2C_ADDR_WIDTH-1:0] addr_q;
  logic                      op_q;
  logic [LEN_WIDTH-1:0]      cnt;
  logic [1:0]                stat_q;

  logic [ID_W-1:0] next_ptr, arb_ptr, arb_id;
  logic [ID_W:0]   arb_j;
  logic            arb_found, in_wait;

  // REPORT arbitrates from the post-transaction pointer so a new grant can follow immediately
  always_comb begin
    next_ptr  = (gnt == LAST_ID) ? '0 : gnt + ID_W'(1);
    arb_ptr   = (state == REPORT) ? next_ptr : rr;
    arb_found = 1'b0;
    arb_id    = '0;
    arb_j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      arb_j = {1'b0, arb_ptr} + (ID_W+1)'(i);
      if (arb_j >= NREQ_W) arb_j = arb_j - NREQ_W;
      if (!arb_found && req_valid_i[arb_j[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_id    = arb_j[ID_W-1:0];
      end
    end
    in_wait = (state == START_WAIT) || (state == ADDR_WAIT) || (state == WR_WAIT) ||
              (state == RD_WAIT) || (state == STOP_WAIT);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;  rr <= '0;  gnt <= '0;
      addr_q <= '0;  op_q <= 1'b0;  cnt <= '0;  stat_q <= ST_DONE;
      req_ready_o <= '0;  wr_ready_o <= '0;
      rd_valid_o <= 1'b0;  rd_data_o <= '0;  rd_last_o <= 1'b0;
      gnt_id_o <= '0;  busy_o <= 1'b0;
      cmd_valid_o <= 1'b0;  cmd_code_o <= '0;  cmd_wdata_o <= '0;
      done_valid_o <= 1'b0;  done_status_o <= ST_DONE;
    end else begin
      req_ready_o  <= '0;
      rd_valid_o   <= 1'b0;
      rd_last_o    <= 1'b0;
      done_valid_o <= 1'b0;
      if (in_wait && rsp_valid_i && rsp_status_i != ST_DONE) begin
        // ARB_LOST means the bus is gone: no STOP; any other failure of STOP itself is an error
        if (rsp_status_i == ST_ARB || state == STOP_WAIT) begin
          done_valid_o  <= 1'b1;
          done_status_o <= (rsp_status_i == ST_ARB) ? ST_ARB : ST_ERR;
          state         <= REPORT;
        end else begin
          stat_q <= (rsp_status_i == ST_NAK && (state == ADDR_WAIT || state == WR_WAIT))
                    ? ST_NAK : ST_ERR;
          cmd_valid_o <= 1'b1;  cmd_code_o <= C_STOP;  state <= STOP_CMD;
        end
      end else begin
        case (state)
          IDLE, REPORT: begin
            if (state == REPORT) rr <= next_ptr;
            if (arb_found) begin
              gnt         <= arb_id;
              gnt_id_o    <= arb_id;
              busy_o      <= 1'b1;
              req_ready_o <= NUM_REQ'(1) << arb_id;
              state       <= GRANT;
            end else begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end
          end
          GRANT: begin
            addr_q      <= req_addr_i[gnt*I2C_ADDR_WIDTH +: I2C_ADDR_WIDTH];
            op_q        <= req_op_i[gnt];
            cnt         <= req_len_i[gnt*LEN_WIDTH +: LEN_WIDTH];
            stat_q      <= ST_DONE;
            cmd_valid_o <= 1'b1;  cmd_code_o <= C_START;  state <= START_CMD;
          end
          START_CMD: if (cmd_ready_i) begin cmd_valid_o <= 1'b0; state <= START_WAIT; end
          ADDR_CMD:  if (cmd_ready_i) begin cmd_valid_o <= 1'b0; state <= ADDR_WAIT;  end
          WR_CMD:    if (cmd_ready_i) begin cmd_valid_o <= 1'b0; state <= WR_WAIT;    end
          RD_CMD:    if (cmd_ready_i) begin cmd_valid_o <= 1'b0; state <= RD_WAIT;    end
          STOP_CMD:  if (cmd_ready_i) begin cmd_valid_o <= 1'b0; state <= STOP_WAIT;  end
          START_WAIT: if (rsp_valid_i) begin
            cmd_valid_o <= 1'b1;  cmd_code_o <= C_WRITE;
            cmd_wdata_o <= I2C_DATA_WIDTH'({addr_q, op_q});
            state       <= ADDR_CMD;
          end
          ADDR_WAIT: if (rsp_valid_i) begin
            if (cnt == '0) begin
              cmd_valid_o <= 1'b1;  cmd_code_o <= C_STOP;  state <= STOP_CMD;
            end else if (!op_q) begin
              wr_ready_o <= NUM_REQ'(1) << gnt;  state <= WFETCH;
            end else begin
              cmd_valid_o <= 1'b1;
              cmd_code_o  <= (cnt == LEN_WIDTH'(1)) ? C_RNAK : C_RACK;
              state       <= RD_CMD;
            end
          end
          WFETCH: if (wr_valid_i[gnt]) begin
            wr_ready_o  <= '0;
            cmd_valid_o <= 1'b1;  cmd_code_o <= C_WRITE;
            cmd_wdata_o <= wr_data_i[gnt*I2C_DATA_WIDTH +: I2C_DATA_WIDTH];
            state       <= WR_CMD;
          end
          WR_WAIT: if (rsp_valid_i) begin
            cnt <= cnt - LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1)) begin
              cmd_valid_o <= 1'b1;  cmd_code_o <= C_STOP;  state <= STOP_CMD;
            end else begin
              wr_ready_o <= NUM_REQ'(1) << gnt;  state <= WFETCH;
            end
          end
          RD_WAIT: if (rsp_valid_i) begin
            rd_valid_o <= 1'b1;
            rd_data_o  <= rsp_rdata_i;
            rd_last_o  <= (cnt == LEN_WIDTH'(1));
            cnt        <= cnt - LEN_WIDTH'(1);
            cmd_valid_o <= 1'b1;
            if (cnt == LEN_WIDTH'(1)) begin
              cmd_code_o <= C_STOP;  state <= STOP_CMD;
            end else begin
              cmd_code_o <= (cnt == LEN_WIDTH'(2)) ? C_RNAK : C_RACK;
              state      <= RD_CMD;
            end
          end
          STOP_WAIT: if (rsp_valid_i) begin
            done_valid_o <= 1'b1;  done_status_o <= stat_q;  state <= REPORT;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Scoreboard bench for i2c_txn_scheduler: directed transactions, a behavioural
// core/requester model, and a monitor that pops expected items as outputs appear.
module tb_i2c_txn_scheduler;
  localparam int N = 4, AW = 7, DW = 8, LW = 4;

  logic clk = 1'b0;
  logic rst_n_i;
  logic [N-1:0] req_valid_i, req_ready_o, req_op_i, wr_valid_i, wr_ready_o;
  logic [N*AW-1:0] req_addr_i;
  logic [N*LW-1:0] req_len_i;
  logic [N*DW-1:0] wr_data_i;
  logic rd_valid_o, rd_last_o, busy_o, cmd_valid_o, cmd_ready_i, rsp_valid_i, done_valid_o;
  logic [DW-1:0] rd_data_o, cmd_wdata_o, rsp_rdata_i;
  logic [1:0] gnt_id_o, rsp_status_i, done_status_o;
  logic [2:0] cmd_code_o;

  i2c_txn_scheduler #(.NUM_REQ(N), .I2C_ADDR_WIDTH(AW), .I2C_DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_op_i(req_op_i), .req_len_i(req_len_i),
    .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
    .gnt_id_o(gnt_id_o), .busy_o(busy_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_code_o(cmd_code_o),
    .cmd_wdata_o(cmd_wdata_o),
    .rsp_valid_i(rsp_valid_i), .rsp_status_i(rsp_status_i), .rsp_rdata_i(rsp_rdata_i),
    .done_valid_o(done_valid_o), .done_status_o(done_status_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] C_WR = 3'b001, C_RACK = 3'b010, C_RNAK = 3'b011, C_START = 3'b100, C_STOP = 3'b101;

  typedef struct { logic [2:0] code; logic [7:0] data; } cmd_t;
  typedef struct { logic [1:0] st; logic [7:0] d; bit hold; } rsp_t;
  typedef struct { logic [7:0] d; logic last; logic [1:0] id; } rd_t;
  typedef struct { logic [1:0] st; logic [1:0] id; } done_t;

  cmd_t  exp_cmd[$];
  rsp_t  rsp_q[$];
  rd_t   exp_rd[$];
  done_t exp_done[$];
  int    exp_gnt[$];
  logic [7:0] wq[$];

  int checks = 0, fails = 0;
  int gnt_seen = 0, done_seen = 0, wr_rdy_cycles = 0, wr_hs = 0;
  bit core_holding = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: event seen/not seen, expected otherwise", name);
  endtask

  task automatic push_cmd(input logic [2:0] code, input logic [7:0] data);
    cmd_t c;
    c.code = code; c.data = data;
    exp_cmd.push_back(c);
  endtask

  task automatic push_rsp(input logic [1:0] st, input logic [7:0] d, input bit hold);
    rsp_t r;
    r.st = st; r.d = d; r.hold = hold;
    rsp_q.push_back(r);
  endtask

  task automatic push_rd(input logic [7:0] d, input logic last, input logic [1:0] id);
    rd_t r;
    r.d = d; r.last = last; r.id = id;
    exp_rd.push_back(r);
  endtask

  task automatic push_done(input logic [1:0] st, input logic [1:0] id);
    done_t e;
    e.st = st; e.id = id;
    exp_done.push_back(e);
  endtask

  // Monitor: every DUT output event consumes one expected item
  initial begin : monitor
    cmd_t c; rd_t r; done_t e; int g;
    forever begin
      @(negedge clk);
      if (rst_n_i) begin
        if (cmd_valid_o && cmd_ready_i) begin
          if (exp_cmd.size() == 0) fail_now("cmd_unexpected");
          else begin
            c = exp_cmd.pop_front();
            chk("cmd_code", cmd_code_o, c.code);
            if (c.code == C_WR) chk("cmd_wdata", cmd_wdata_o, c.data);
          end
        end
        if (rd_valid_o) begin
          if (exp_rd.size() == 0) fail_now("rd_unexpected");
          else begin
            r = exp_rd.pop_front();
            chk("rd_data", rd_data_o, r.d);
            chk("rd_last", rd_last_o, r.last);
            chk("rd_gnt_id", gnt_id_o, r.id);
          end
        end
        if (done_valid_o) begin
          if (exp_done.size() == 0) fail_now("done_unexpected");
          else begin
            e = exp_done.pop_front();
            chk("done_status", done_status_o, e.st);
            chk("done_gnt_id", gnt_id_o, e.id);
            chk("done_busy", busy_o, 1);
          end
          done_seen++;
        end
        if (req_ready_o != '0) begin
          if (exp_gnt.size() == 0) fail_now("grant_unexpected");
          else begin
            g = exp_gnt.pop_front();
            chk("grant_onehot", req_ready_o, 32'(1) << g);
            chk("grant_id", gnt_id_o, g);
            chk("grant_busy", busy_o, 1);
          end
          gnt_seen++;
        end
      end
    end
  end

  // Byte-level core model: accept each command after one cycle, answer one cycle later
  initial begin : core
    rsp_t r;
    cmd_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_status_i = '0; rsp_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n_i && cmd_valid_o) begin
        cmd_ready_i = 1'b1;
        @(posedge clk); #1;
        cmd_ready_i = 1'b0;
        if (rsp_q.size() == 0) begin
          fail_now("rsp_underflow");
          r.st = 2'b00; r.d = 8'h00; r.hold = 1'b0;
        end else r = rsp_q.pop_front();
        if (r.hold) begin
          core_holding = 1'b1;
          wait (!rst_n_i);
          wait (rst_n_i);
          core_holding = 1'b0;
        end else begin
          @(posedge clk); #1;
          rsp_valid_i = 1'b1; rsp_status_i = r.st; rsp_rdata_i = r.d;
          @(posedge clk); #1;
          rsp_valid_i = 1'b0;
        end
      end
    end
  end

  // Write-data source: offers the head of wq to every lane while bytes remain
  initial begin : wr_src
    bit hs;
    wr_valid_i = '0; wr_data_i = '0;
    forever begin
      @(negedge clk);
      hs = rst_n_i && (|(wr_ready_o & wr_valid_i));
      if (rst_n_i && |wr_ready_o) wr_rdy_cycles++;
      @(posedge clk); #1;
      if (hs && wq.size() > 0) begin
        void'(wq.pop_front());
        wr_hs++;
      end
      wr_valid_i = (wq.size() > 0) ? '1 : '0;
      wr_data_i  = (wq.size() > 0) ? {N{wq[0]}} : '0;
    end
  end

  task automatic issue(input int id, input logic [6:0] addr, input logic op, input logic [3:0] len, input bit lat);
    int n;
    @(posedge clk); #1;
    req_addr_i[id*AW +: AW] = addr;
    req_op_i[id]            = op;
    req_len_i[id*LW +: LW]  = len;
    req_valid_i[id]         = 1'b1;
    exp_gnt.push_back(id);
    if (lat) begin
      @(posedge clk); @(negedge clk);
      chk("grant_latency", req_ready_o[id], 1);
    end else begin
      n = 0;
      while (!req_ready_o[id] && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) fail_now("grant_timeout");
    end
    @(posedge clk); #1;
    // fields must already be latched; scramble them to prove it
    req_valid_i[id]         = 1'b0;
    req_addr_i[id*AW +: AW] = '1;
    req_len_i[id*LW +: LW]  = '1;
    req_op_i[id]            = ~op;
    if (lat) begin
      @(negedge clk);
      chk("start_latency", cmd_valid_o, 1);
      chk("start_code", cmd_code_o, C_START);
    end
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 3000) begin @(negedge clk); n++; end
    if (done_seen < target) fail_now("done_timeout");
  endtask

  task automatic drained();
    chk("cmd_queue_left", exp_cmd.size(), 0);
    chk("rsp_queue_left", rsp_q.size(), 0);
    chk("rd_queue_left", exp_rd.size(), 0);
    chk("done_queue_left", exp_done.size(), 0);
    chk("grant_queue_left", exp_gnt.size(), 0);
  endtask

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, n;
    rst_n_i = 1'b0;
    req_valid_i = '0; req_addr_i = '0; req_op_i = '0; req_len_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_wr_ready", wr_ready_o, 0);
    chk("rst_rd_valid", rd_valid_o, 0);
    chk("rst_rd_data", rd_data_o, 0);
    chk("rst_rd_last", rd_last_o, 0);
    chk("rst_gnt_id", gnt_id_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cmd_valid", cmd_valid_o, 0);
    chk("rst_cmd_code", cmd_code_o, 0);
    chk("rst_cmd_wdata", cmd_wdata_o, 0);
    chk("rst_done_valid", done_valid_o, 0);
    chk("rst_done_status", done_status_o, 0);
    @(posedge clk); #1 rst_n_i = 1'b1;

    // 2-byte write from req0
    push_cmd(C_START, 0); push_cmd(C_WR, 8'h44); push_cmd(C_WR, 8'hA5);
    push_cmd(C_WR, 8'h5A); push_cmd(C_STOP, 0);
    repeat (5) push_rsp(2'b00, 0, 0);
    push_done(2'b00, 0);
    wq.push_back(8'hA5); wq.push_back(8'h5A);
    base = wr_hs;
    issue(0, 7'h22, 1'b0, 4'd2, 1'b1);
    wait_done(1);
    chk("t1_write_handshakes", wr_hs - base, 2);
    drained();

    // 3-byte read from req1
    push_cmd(C_START, 0); push_cmd(C_WR, 8'h45); push_cmd(C_RACK, 0);
    push_cmd(C_RACK, 0); push_cmd(C_RNAK, 0); push_cmd(C_STOP, 0);
    push_rsp(2'b00, 0, 0); push_rsp(2'b00, 0, 0); push_rsp(2'b00, 8'h11, 0);
    push_rsp(2'b00, 8'h22, 0); push_rsp(2'b00, 8'h33, 0); push_rsp(2'b00, 0, 0);
    push_rd(8'h11, 0, 1); push_rd(8'h22, 0, 1); push_rd(8'h33, 1, 1);
    push_done(2'b00, 1);
    issue(1, 7'h22, 1'b1, 4'd3, 1'b0);
    wait_done(2);
    drained();

    // address NAK from req2
    push_cmd(C_START, 0); push_cmd(C_WR, 8'h20); push_cmd(C_STOP, 0);
    push_rsp(2'b00, 0, 0); push_rsp(2'b01, 0, 0); push_rsp(2'b00, 0, 0);
    push_done(2'b01, 2);
    base = wr_rdy_cycles;
    issue(2, 7'h10, 1'b0, 4'd4, 1'b0);
    wait_done(3);
    chk("t3_wr_ready_cycles", wr_rdy_cycles - base, 0);
    drained();

    // ARB_LOST on the second data write from req3: no STOP expected
    push_cmd(C_START, 0); push_cmd(C_WR, 8'h78); push_cmd(C_WR, 8'h01); push_cmd(C_WR, 8'h02);
    push_rsp(2'b00, 0, 0); push_rsp(2'b00, 0, 0); push_rsp(2'b00, 0, 0); push_rsp(2'b10, 0, 0);
    push_done(2'b10, 3);
    wq.push_back(8'h01); wq.push_back(8'h02); wq.push_back(8'h03);
    issue(3, 7'h3C, 1'b0, 4'd3, 1'b0);
    wait_done(4);
    repeat (10) @(negedge clk);
    wq.delete();
    chk("t4_busy_after", busy_o, 0);
    drained();

    // contention: all four probe continuously, expect 0,1,2,3,0
    for (int k = 0; k < 5; k++) begin
      push_cmd(C_START, 0);
      push_cmd(C_WR, 8'(((8'h30 + (k % 4)) << 1)));
      push_cmd(C_STOP, 0);
      repeat (3) push_rsp(2'b00, 0, 0);
      push_done(2'b00, 2'(k % 4));
      exp_gnt.push_back(k % 4);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      req_addr_i[k*AW +: AW] = 7'(8'h30 + k);
      req_len_i[k*LW +: LW]  = '0;
    end
    req_op_i = '0;
    base = gnt_seen;
    req_valid_i = '1;
    n = 0;
    while (gnt_seen < base + 5 && n < 3000) begin @(negedge clk); n++; end
    if (gnt_seen < base + 5) fail_now("contention_timeout");
    @(posedge clk); #1 req_valid_i = '0;
    wait_done(9);
    drained();

    // reset during the second READ_ACK wait of a read from req1
    push_cmd(C_START, 0); push_cmd(C_WR, 8'hA1); push_cmd(C_RACK, 0); push_cmd(C_RACK, 0);
    push_rsp(2'b00, 0, 0); push_rsp(2'b00, 0, 0); push_rsp(2'b00, 8'h99, 0); push_rsp(2'b00, 0, 1);
    push_rd(8'h99, 0, 1);
    issue(1, 7'h50, 1'b1, 4'd3, 1'b0);
    n = 0;
    while (!core_holding && n < 500) begin @(negedge clk); n++; end
    if (!core_holding) fail_now("hold_timeout");
    @(negedge clk);
    chk("t6_busy_before_reset", busy_o, 1);
    @(posedge clk); #2 rst_n_i = 1'b0;
    #1;
    chk("t6_reset_cmd_valid", cmd_valid_o, 0);
    chk("t6_reset_busy", busy_o, 0);
    chk("t6_reset_gnt_id", gnt_id_o, 0);
    chk("t6_reset_wr_ready", wr_ready_o, 0);
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b1;
    drained();

    // after reset, req3 alone is granted and runs a 1-byte write
    push_cmd(C_START, 0); push_cmd(C_WR, 8'hFE); push_cmd(C_WR, 8'hC3); push_cmd(C_STOP, 0);
    repeat (4) push_rsp(2'b00, 0, 0);
    push_done(2'b00, 3);
    wq.push_back(8'hC3);
    issue(3, 7'h7F, 1'b0, 4'd1, 1'b0);
    wait_done(10);
    drained();

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
